scan_addr_gen: RTL and testbench

SCAN_ADDR_GEN -- requirements
Module: scan_addr_gen

---
 rtl/scan_addr_gen.sv | 181 ++++++++++++++++++
 tb/tb_scan_addr_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_addr_gen.sv
// scan_addr_gen: address sequencer for one BLK x BLK sample block.
// Emits row-major addresses (y*BLK + x) in raster or zigzag order with a
// valid/ready handshake, then pulses done for one cycle and advances to the
// next of BANKS block buffers. Back-to-back blocks are possible by issuing
// start in the done cycle.
//
// Optional feature: define SCAN_ADDR_GEN_ABORT_EN to add an abort input that
// drops an in-progress scan back to idle without a done pulse and without
// advancing the bank.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; outputs quiet
// S_SCAN | presenting addresses; one step per accepted beat
// S_DONE | single-cycle block-complete pulse; start accepted here too
module scan_addr_gen #(
    parameter int BLK   = 8,
    parameter int BANKS = 2,
    localparam int LW   = $clog2(BLK),
    localparam int AW   = 2 * LW,
    localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          ready,
`ifdef SCAN_ADDR_GEN_ABORT_EN
    input  logic          abort,
`endif
    output logic          valid,
    output logic [AW-1:0] addr,
    output logic [BW-1:0] bank,
    output logic          last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LW-1:0] XY_MAX   = LW'(BLK - 1);
    localparam logic [BW-1:0] BANK_MAX = BW'(BANKS - 1);

    state_t          state_q, state_d;
    logic [LW-1:0]   x_q, x_d;
    logic [LW-1:0]   y_q, y_d;
    logic            mode_q, mode_d;
    logic [BW-1:0]   bank_q, bank_d;

    logic [LW-1:0]   x_step, y_step;
    logic [BW-1:0]   bank_inc;
    logic            at_end;
    logic            beat_acc;
    logic            abort_hit;

    assign at_end   = (x_q == XY_MAX) && (y_q == XY_MAX);
    assign beat_acc = (state_q == S_SCAN) && ready;

`ifdef SCAN_ADDR_GEN_ABORT_EN
    assign abort_hit = (state_q == S_SCAN) && abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Next bank index; with a single bank this stays at zero.
    always_comb begin
        bank_inc = bank_q + BW'(1);
        if (bank_q == BANK_MAX) begin
            bank_inc = '0;
        end
    end

    // Next (x, y) position for the registered scan order.
    always_comb begin
        x_step = x_q;
        y_step = y_q;
        if (!mode_q) begin
            // Raster: walk along the row, then wrap to the next row.
            if (x_q == XY_MAX) begin
                x_step = '0;
                y_step = y_q + LW'(1);
            end else begin
                x_step = x_q + LW'(1);
            end
        end else if ((x_q[0] ^ y_q[0]) == 1'b0) begin
            // Zigzag, even anti-diagonal: travelling up-right.
            if (x_q == XY_MAX) begin
                y_step = y_q + LW'(1);
            end else if (y_q == '0) begin
                x_step = x_q + LW'(1);
            end else begin
                x_step = x_q + LW'(1);
                y_step = y_q - LW'(1);
            end
        end else begin
            // Zigzag, odd anti-diagonal: travelling down-left.
            if (y_q == XY_MAX) begin
                x_step = x_q + LW'(1);
            end else if (x_q == '0) begin
                y_step = y_q + LW'(1);
            end else begin
                x_step = x_q - LW'(1);
                y_step = y_q + LW'(1);
            end
        end
    end

    // Next-state logic: start acceptance, beat stepping, completion, abort.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        bank_d  = bank_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SCAN;
                    mode_d  = mode;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (abort_hit) begin
                    // Abort takes priority over a last-beat acceptance.
                    state_d = S_IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end else if (beat_acc) begin
                    if (at_end) begin
                        // Clear position so addr reads zero outside the scan.
                        state_d = S_DONE;
                        x_d     = '0;
                        y_d     = '0;
                        bank_d  = bank_inc;
                    end else begin
                        x_d = x_step;
                        y_d = y_step;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                x_d     = '0;
                y_d     = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= 1'b0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            bank_q  <= bank_d;
        end
    end

    assign valid = (state_q == S_SCAN);
    assign busy  = (state_q == S_SCAN);
    assign done  = (state_q == S_DONE);
    assign addr  = {y_q, x_q};
    assign bank  = bank_q;
    assign last  = (state_q == S_SCAN) && at_end;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Directed bench for scan_addr_gen with BLK=8, BANKS=2.
// Abort checks are included when SCAN_ADDR_GEN_ABORT_EN is defined.
module tb_scan_addr_gen;

    localparam int BLK   = 8;
    localparam int BANKS = 2;
    localparam int LW    = $clog2(BLK);
    localparam int AW    = 2 * LW;
    localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int NB    = BLK * BLK;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          ready = 1'b0;
    logic          abort = 1'b0;
    logic          valid;
    logic [AW-1:0] addr;
    logic [BW-1:0] bank;
    logic          last;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;
    int exp_bank = 0;
    int zz [NB];

    typedef struct {
        logic start;
        logic mode;
        logic ready;
        logic e_valid;
        int   e_addr;
        int   e_bank;
        logic e_last;
        logic e_busy;
        logic e_done;
    } vec_t;

    vec_t tv [12];

    scan_addr_gen #(.BLK(BLK), .BANKS(BANKS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .ready (ready),
`ifdef SCAN_ADDR_GEN_ABORT_EN
        .abort (abort),
`endif
        .valid (valid),
        .addr  (addr),
        .bank  (bank),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input int ea, input int eb,
                         input logic el, input logic ebz, input logic ed);
        n_vec++;
        if (valid !== ev || addr !== AW'(ea) || bank !== BW'(eb) || last !== el ||
            busy !== ebz || done !== ed) begin
            n_err++;
            $display("FAIL %s: got valid=%0b addr=%0d bank=%0d last=%0b busy=%0b done=%0b, want valid=%0b addr=%0d bank=%0d last=%0b busy=%0b done=%0b",
                     name, valid, addr, bank, last, busy, done, ev, ea, eb, el, ebz, ed);
        end
    endtask

    // One full block from a non-busy state, ending observed in the done cycle.
    task automatic drive_block(input logic m);
        start = 1'b1;
        mode  = m;
        ready = 1'b1;
        tick();
        check("blk_first", 1'b1, 0, exp_bank, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        mode  = ~m;
        for (int k = 1; k < NB; k++) begin
            tick();
            check($sformatf("blk_beat%0d_m%0b", k, m), 1'b1, m ? zz[k] : k, exp_bank,
                  (k == NB - 1), 1'b1, 1'b0);
        end
        tick();
        exp_bank = (exp_bank + 1) % BANKS;
        check("blk_done", 1'b0, 0, exp_bank, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Zigzag order built diagonal by diagonal.
        begin
            int idx;
            idx = 0;
            for (int s = 0; s <= 2 * BLK - 2; s++) begin
                int lo, hi;
                lo = (s - (BLK - 1) > 0) ? s - (BLK - 1) : 0;
                hi = (s < BLK - 1) ? s : BLK - 1;
                if (s % 2 == 0) begin
                    for (int x = lo; x <= hi; x++) begin
                        zz[idx] = (s - x) * BLK + x;
                        idx++;
                    end
                end else begin
                    for (int x = hi; x >= lo; x--) begin
                        zz[idx] = (s - x) * BLK + x;
                        idx++;
                    end
                end
            end
        end

        //        start mode ready  valid addr bank last busy done
        tv[0]  = '{1'b0, 1'b0, 1'b1, 1'b0,  0, 0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b1,  0, 0, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 1'b1, 1'b1,  1, 0, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 1'b1,  8, 0, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16, 0, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 1'b1, 1'b1,  9, 0, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 1'b1,  9, 0, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b1,  9, 0, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b1,  9, 0, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1,  2, 0, 1'b0, 1'b1, 1'b0};
        tv[10] = '{1'b1, 1'b0, 1'b1, 1'b1,  3, 0, 1'b0, 1'b1, 1'b0};
        tv[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 10, 0, 1'b0, 1'b1, 1'b0};

        // Reset state, with start asserted during reset.
        start = 1'b1;
        tick();
        tick();
        check("reset_state", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        rst   = 1'b0;

        // Table: zigzag start, stall on addr 9, ignored start and mode change.
        for (int i = 0; i < 12; i++) begin
            start = tv[i].start;
            mode  = tv[i].mode;
            ready = tv[i].ready;
            tick();
            check($sformatf("vec%0d", i), tv[i].e_valid, tv[i].e_addr, tv[i].e_bank,
                  tv[i].e_last, tv[i].e_busy, tv[i].e_done);
        end
        start = 1'b0;

        // Finish the zigzag block.
        for (int k = 8; k < NB; k++) begin
            ready = 1'b1;
            tick();
            check($sformatf("zz_beat%0d", k), 1'b1, zz[k], 0, (k == NB - 1), 1'b1, 1'b0);
        end
        tick();
        exp_bank = 1;
        check("zz_done", 1'b0, 0, 1, 1'b0, 1'b0, 1'b1);
        tick();
        check("zz_done_once", 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);

        // Raster block from idle, bank wraps 1 -> 0.
        drive_block(1'b0);

        // Three starts issued in the done cycle: banks 0, 1, 0.
        drive_block(1'b1);
        drive_block(1'b0);
        drive_block(1'b1);
        tick();
        check("chain_idle", 1'b0, 0, exp_bank, 1'b0, 1'b0, 1'b0);

        // Reset mid-scan at beat 20.
        start = 1'b1;
        mode  = 1'b1;
        ready = 1'b1;
        tick();
        check("rst_scan_first", 1'b1, 0, exp_bank, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("rst_scan_beat%0d", k), 1'b1, zz[k], exp_bank, 1'b0, 1'b1, 1'b0);
        end
        rst = 1'b1;
        tick();
        check("rst_mid", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_bank = 0;
        tick();
        check("rst_no_done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        drive_block(1'b0);
        tick();
        check("post_rst_idle", 1'b0, 0, exp_bank, 1'b0, 1'b0, 1'b0);

`ifdef SCAN_ADDR_GEN_ABORT_EN
        // Abort at beat 10.
        start = 1'b1;
        mode  = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        check("ab_first", 1'b1, 0, exp_bank, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("ab_beat%0d", k), 1'b1, zz[k], exp_bank, 1'b0, 1'b1, 1'b0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_mid", 1'b0, 0, exp_bank, 1'b0, 1'b0, 1'b0);
        tick();
        check("ab_mid_no_done", 1'b0, 0, exp_bank, 1'b0, 1'b0, 1'b0);

        // Abort in idle is ignored; start still accepted.
        start = 1'b1;
        abort = 1'b1;
        mode  = 1'b0;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("ab_idle_start", 1'b1, 0, exp_bank, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k < NB; k++) begin
            tick();
            check($sformatf("ab2_beat%0d", k), 1'b1, k, exp_bank, (k == NB - 1), 1'b1, 1'b0);
        end
        // Abort together with last-beat acceptance.
        abort = 1'b1;
        ready = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_last", 1'b0, 0, exp_bank, 1'b0, 1'b0, 1'b0);
        tick();
        check("ab_last_no_done", 1'b0, 0, exp_bank, 1'b0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
